// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter: arbitrates DDR write/read burst requests, issues one command per burst, streams word acks.
// Optional macro ARB_ROUND_ROBIN_EN: alternate write/read on ties instead of fixed write priority.
module ddr_burst_arbiter #(
    parameter int LEN_W     = 10,
    parameter int ADDR_W    = 25,
    parameter int GUARD_CYC = 2
) (
    input  logic              clk_ref,
    input  logic              rst,
    input  logic              ddr_init_done,
    input  logic              ddr_wr_req,
    input  logic              ddr_rd_req,
    input  logic [ADDR_W-1:0] ddr_wraddr,
    input  logic [ADDR_W-1:0] ddr_rdaddr,
    input  logic [LEN_W-1:0]  wr_length,
    input  logic [LEN_W-1:0]  rd_length,
    output logic              ddr_wr_ack,
    output logic              ddr_wr_finish,
    output logic              ddr_rd_ack,
    output logic              ddr_rd_finish,
    output logic              app_cmd_en,
    output logic              app_cmd_wr,
    output logic [ADDR_W-1:0] app_cmd_addr,
    output logic [LEN_W-1:0]  app_cmd_len,
    input  logic              app_cmd_rdy,
    input  logic              app_wdata_rdy,
    output logic              app_wdata_en,
    input  logic              app_rdata_valid,
    output logic              arb_busy
);
    localparam int GW = $clog2(GUARD_CYC + 2);

    typedef enum logic [2:0] {IDLE, WCMD, WDATA, RCMD, RDATA, DONE} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len, r_cnt;
    logic [GW-1:0]     r_guard;
    logic              r_wdata_en;
    logic              w_can_grant, w_gnt_wr, w_gnt_rd, w_last_word, w_len_zero;

    assign w_can_grant = r_state == IDLE && r_guard == '0 && ddr_init_done;
    assign w_last_word = r_cnt == r_len - 1'b1;
    assign w_len_zero  = r_len == '0;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_wr;

    // On a tie, grant the type that did not win last time.
    assign w_gnt_wr = w_can_grant && ddr_wr_req && (!ddr_rd_req || !r_last_wr);

    always_ff @(posedge clk_ref or posedge rst)
        if (rst)
            r_last_wr <= 1'b0;
        else if (w_gnt_wr || w_gnt_rd)
            r_last_wr <= w_gnt_wr;
`else
    assign w_gnt_wr = w_can_grant && ddr_wr_req;
`endif
    assign w_gnt_rd = w_can_grant && ddr_rd_req && !w_gnt_wr;

    always_ff @(posedge clk_ref or posedge rst)
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_gnt_wr ? WCMD : w_gnt_rd ? RCMD : IDLE;
            WCMD:    w_next = w_len_zero ? DONE : app_cmd_rdy ? WDATA : WCMD;
            WDATA:   w_next = app_wdata_rdy && w_last_word ? DONE : WDATA;
            RCMD:    w_next = w_len_zero ? DONE : app_cmd_rdy ? RDATA : RCMD;
            RDATA:   w_next = app_rdata_valid && w_last_word ? DONE : RDATA;
            default: w_next = IDLE;
        endcase
    end

    // A zero-length grant skips the command and reports finish from the CMD state.
    always_comb begin
        app_cmd_en    = (r_state == WCMD || r_state == RCMD) && !w_len_zero;
        app_cmd_wr    = r_state == WCMD;
        ddr_wr_ack    = r_state == WDATA && app_wdata_rdy;
        ddr_rd_ack    = r_state == RDATA && app_rdata_valid;
        ddr_wr_finish = (ddr_wr_ack && w_last_word) || (r_state == WCMD && w_len_zero);
        ddr_rd_finish = (ddr_rd_ack && w_last_word) || (r_state == RCMD && w_len_zero);
        arb_busy      = r_state != IDLE;
    end

    assign app_cmd_addr = r_addr;
    assign app_cmd_len  = r_len;
    assign app_wdata_en = r_wdata_en;

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_guard    <= '0;
            r_wdata_en <= 1'b0;
        end else begin
            r_wdata_en <= ddr_wr_ack;
            if (w_gnt_wr || w_gnt_rd) begin
                r_addr <= w_gnt_wr ? ddr_wraddr : ddr_rdaddr;
                r_len  <= w_gnt_wr ? wr_length : rd_length;
                r_cnt  <= '0;
            end else if (ddr_wr_ack || ddr_rd_ack) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == DONE)
                r_guard <= GW'(GUARD_CYC);
            else if (r_state == IDLE && r_guard != '0)
                r_guard <= r_guard - 1'b1;
        end
    end
endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// tb_ddr_burst_arbiter: randomized scoreboard bench for ddr_burst_arbiter.
// Stimulus pushes expected commands/bursts; a negedge monitor pops and compares.
module tb_ddr_burst_arbiter;
    localparam int LEN_W     = 10;
    localparam int ADDR_W    = 25;
    localparam int GUARD_CYC = 2;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } burst_t;

    logic              clk_ref = 0;
    logic              rst = 1;
    logic              ddr_init_done = 0;
    logic              ddr_wr_req = 0;
    logic              ddr_rd_req = 0;
    logic [ADDR_W-1:0] ddr_wraddr = '0;
    logic [ADDR_W-1:0] ddr_rdaddr = '0;
    logic [LEN_W-1:0]  wr_length = '0;
    logic [LEN_W-1:0]  rd_length = '0;
    logic              app_cmd_rdy = 0;
    logic              app_wdata_rdy = 0;
    logic              app_rdata_valid = 0;
    logic              ddr_wr_ack, ddr_wr_finish, ddr_rd_ack, ddr_rd_finish;
    logic              app_cmd_en, app_cmd_wr, app_wdata_en, arb_busy;
    logic [ADDR_W-1:0] app_cmd_addr;
    logic [LEN_W-1:0]  app_cmd_len;

    ddr_burst_arbiter #(.LEN_W(LEN_W), .ADDR_W(ADDR_W), .GUARD_CYC(GUARD_CYC)) dut (
        .clk_ref(clk_ref), .rst(rst), .ddr_init_done(ddr_init_done),
        .ddr_wr_req(ddr_wr_req), .ddr_rd_req(ddr_rd_req),
        .ddr_wraddr(ddr_wraddr), .ddr_rdaddr(ddr_rdaddr),
        .wr_length(wr_length), .rd_length(rd_length),
        .ddr_wr_ack(ddr_wr_ack), .ddr_wr_finish(ddr_wr_finish),
        .ddr_rd_ack(ddr_rd_ack), .ddr_rd_finish(ddr_rd_finish),
        .app_cmd_en(app_cmd_en), .app_cmd_wr(app_cmd_wr),
        .app_cmd_addr(app_cmd_addr), .app_cmd_len(app_cmd_len),
        .app_cmd_rdy(app_cmd_rdy), .app_wdata_rdy(app_wdata_rdy),
        .app_wdata_en(app_wdata_en), .app_rdata_valid(app_rdata_valid),
        .arb_busy(arb_busy)
    );

    always #5 clk_ref = ~clk_ref;

    int     errors = 0, checks = 0;
    burst_t cmd_q[$];
    burst_t fin_q[$];
    bit     m_last_wr = 0;
    int     ack_cnt = 0, cyc = 0, last_fin = -1000;
    bit     prev_ack = 0, prev_cmd_en = 0;
    bit     fix_rdy = 0;
    int     w_pct = 100, r_pct = 50, en_cnt = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: a tie goes to write, or alternates when round robin is built.
    function automatic bit pick_wr(bit w, bit r);
        if (w && r) begin
`ifdef ARB_ROUND_ROBIN_EN
            return !m_last_wr;
`else
            return 1'b1;
`endif
        end
        return w;
    endfunction

    task automatic expect_burst(bit w, bit r);
        burst_t b;
        b.wr      = pick_wr(w, r);
        m_last_wr = b.wr;
        b.addr    = b.wr ? ddr_wraddr : ddr_rdaddr;
        b.len     = b.wr ? wr_length : rd_length;
        if (b.len != 0) cmd_q.push_back(b);
        fin_q.push_back(b);
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk_ref);
        #1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (fin_q.size() != 0 && n < 5000) begin
            @(negedge clk_ref);
            #1;
            n++;
        end
        chk("burst_timeout", fin_q.size(), 0);
        chk("cmd_drained", cmd_q.size(), 0);
        fin_q.delete();
        cmd_q.delete();
        ddr_wr_req = 0;
        ddr_rd_req = 0;
    endtask

    always @(posedge clk_ref) begin
        #1;
        en_cnt          = app_cmd_en ? en_cnt + 1 : 0;
        app_cmd_rdy     = fix_rdy ? (en_cnt >= 3) : ($urandom_range(0, 2) == 0);
        app_wdata_rdy   = $urandom_range(0, 99) < w_pct;
        app_rdata_valid = $urandom_range(0, 99) < r_pct;
    end

    always @(negedge clk_ref) begin
        burst_t e;
        cyc++;
        if (rst) begin
            chk("reset_outputs", {ddr_wr_ack, ddr_wr_finish, ddr_rd_ack, ddr_rd_finish, app_cmd_en,
                app_cmd_wr, app_cmd_addr, app_cmd_len, app_wdata_en, arb_busy}, 0);
            prev_ack    = 0;
            prev_cmd_en = 0;
            ack_cnt     = 0;
            last_fin    = -1000;
        end else begin
            chk("wdata_en_lag", app_wdata_en, prev_ack);
            prev_ack = ddr_wr_ack;
            if (app_cmd_en && !prev_cmd_en)
                chk("inter_burst_gap", (cyc - last_fin) > 1 + GUARD_CYC, 1);
            prev_cmd_en = app_cmd_en;
            if (app_cmd_en && app_cmd_rdy) begin
                chk("cmd_expected", cmd_q.size() > 0, 1);
                if (cmd_q.size() > 0) begin
                    e = cmd_q.pop_front();
                    chk("cmd_fields", {app_cmd_wr, app_cmd_addr, app_cmd_len}, {e.wr, e.addr, e.len});
                end
            end
            if (ddr_wr_ack || ddr_rd_ack) begin
                chk("ack_expected", fin_q.size() > 0, 1);
                chk("ack_exclusive", ddr_wr_ack && ddr_rd_ack, 0);
                if (fin_q.size() > 0) chk("ack_type", ddr_wr_ack, fin_q[0].wr);
                ack_cnt++;
            end
            if (ddr_wr_finish || ddr_rd_finish) begin
                chk("finish_expected", fin_q.size() > 0, 1);
                if (fin_q.size() > 0) begin
                    e = fin_q.pop_front();
                    chk("finish_type", {ddr_wr_finish, ddr_rd_finish}, {e.wr, !e.wr});
                    chk("finish_words", ack_cnt, e.len);
                end
                ack_cnt  = 0;
                last_fin = cyc;
            end
        end
    end

    initial begin
        ddr_wr_req = 1;
        ddr_rd_req = 1;
        idle(3);
        rst = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_ref);
            #1;
            if (i % 20 == 0)
                chk("no_grant_before_init", {app_cmd_en, arb_busy, ddr_wr_finish, ddr_rd_finish}, 0);
        end
        ddr_wr_req    = 0;
        ddr_rd_req    = 0;
        ddr_init_done = 1;
        idle(3);

        // 256-word write, command accepted after 3 cycles, write data always ready
        fix_rdy    = 1;
        w_pct      = 100;
        wr_length  = 256;
        ddr_wraddr = 25'h1000;
        expect_burst(1, 0);
        ddr_wr_req = 1;
        @(negedge clk_ref);
        chk("grant_latency", app_cmd_en, 1);
        #1;
        wait_done();

        // 256-word read with 50% valid, then a stretch of spurious valids
        fix_rdy    = 0;
        rd_length  = 256;
        ddr_rdaddr = ADDR_W'($urandom);
        expect_burst(0, 1);
        ddr_rd_req = 1;
        wait_done();
        r_pct = 100;
        idle(10);
        r_pct = 50;

        // Both requests held across four bursts
        w_pct      = 70;
        wr_length  = 12;
        rd_length  = 9;
        ddr_wraddr = ADDR_W'($urandom);
        ddr_rdaddr = ADDR_W'($urandom);
        for (int i = 0; i < 4; i++) expect_burst(1, 1);
        ddr_wr_req = 1;
        ddr_rd_req = 1;
        wait_done();
        idle(5);

        // Zero-length write
        wr_length = 0;
        expect_burst(1, 0);
        ddr_wr_req = 1;
        wait_done();
        idle(6);

        // Reset at word 100 of a 256-word write
        w_pct      = 100;
        wr_length  = 256;
        ddr_wraddr = ADDR_W'($urandom);
        expect_burst(1, 0);
        ddr_wr_req = 1;
        for (int n = 0; n < 2000 && ack_cnt < 100; n++) begin
            @(negedge clk_ref);
            #1;
        end
        chk("reached_word_100", ack_cnt, 100);
        rst = 1;
        #1;
        chk("async_reset_outputs", {ddr_wr_ack, ddr_wr_finish, ddr_rd_ack, ddr_rd_finish, app_cmd_en,
            app_cmd_wr, app_cmd_addr, app_cmd_len, app_wdata_en, arb_busy}, 0);
        cmd_q.delete();
        fin_q.delete();
        m_last_wr  = 0;
        ddr_wr_req = 0;
        idle(2);
        rst        = 0;
        ddr_wraddr = ADDR_W'($urandom);
        wr_length  = 20;
        expect_burst(1, 0);
        ddr_wr_req = 1;
        wait_done();

        // Randomized mix of writes, reads, ties and zero lengths
        w_pct = 70;
        for (int i = 0; i < 25; i++) begin
            int kind = $urandom_range(0, 2);
            wr_length  = LEN_W'($urandom_range(0, 12));
            rd_length  = LEN_W'($urandom_range(0, 12));
            ddr_wraddr = ADDR_W'($urandom);
            ddr_rdaddr = ADDR_W'($urandom);
            expect_burst(kind != 1, kind != 0);
            ddr_wr_req = kind != 1;
            ddr_rd_req = kind != 0;
            wait_done();
            idle($urandom_range(0, 4));
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
